// File: rtl/uart_pkg.sv
// uart_pkg: shared UART parity/state enums, baud-rate constants and baud_div(clk_freq, sel) divisor helper
package uart_pkg;
    typedef enum logic [1:0] {PAR_NONE = 2'b00, PAR_ODD = 2'b01, PAR_EVEN = 2'b10, PAR_MARK = 2'b11} parity_e;
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} tx_state_e;
    localparam int BAUD_4800   = 4800;
    localparam int BAUD_9600   = 9600;
    localparam int BAUD_19200  = 19200;
    localparam int BAUD_115200 = 115200;
    function automatic logic [15:0] baud_div(input int clk_freq, input logic [1:0] sel);
        return sel == 2'b00 ? 16'(clk_freq / BAUD_4800) :
               sel == 2'b01 ? 16'(clk_freq / BAUD_9600) :
               sel == 2'b10 ? 16'(clk_freq / BAUD_19200) : 16'(clk_freq / BAUD_115200);
    endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: sync FIFO (sys_clk, rst_n, push/din in, pop -> registered dout, full/empty/count out)
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                           sys_clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               din,
    output logic [WIDTH-1:0]               dout,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    assign empty = wr_ptr == rd_ptr;
    assign full  = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
    assign count = wr_ptr - rd_ptr;
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            dout   <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) begin
                dout   <= mem[rd_ptr[AW-1:0]];
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
    always_ff @(posedge sys_clk)
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: UART TX (sel_baud/parity_mode/two_stop cfg, tx_valid/tx_d_in/tx_ready push, tx_data line, tx_status/fifo_count/overflow)
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                              sys_clk,
    input  logic                              rst_n,
    input  logic [1:0]                        sel_baud,
    input  logic [1:0]                        parity_mode,
    input  logic                              two_stop,
    input  logic                              tx_valid,
    input  logic [DATA_BITS-1:0]              tx_d_in,
    output logic                              tx_ready,
    output logic                              tx_data,
    output logic                              tx_status,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              overflow
);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_START  = ST_START;
    localparam logic [2:0] S_DATA   = ST_DATA;
    localparam logic [2:0] S_PARITY = ST_PARITY;
    localparam logic [2:0] S_STOP   = ST_STOP;
    logic [2:0] state, state_nxt;
    logic [15:0] div_r, baud_cnt;
    logic [BW-1:0] bit_cnt;
    logic [DATA_BITS-1:0] shreg, dout;
    logic par_r, two_stop_r, full, empty, tick, last_bit, stop_done, do_push, do_pop, line;
    parity_e pmode_r;

    assign tx_ready  = !full;
    assign do_push   = tx_valid && !full;
    assign tick      = state != S_IDLE && baud_cnt == div_r - 16'd1;
    assign last_bit  = bit_cnt == BW'(DATA_BITS - 1);
    assign stop_done = tick && state == S_STOP && (!two_stop_r || bit_cnt != '0);
    assign do_pop    = !empty && (state == S_IDLE || stop_done);
    assign line      = state == S_START ? 1'b0 : state == S_DATA ? shreg[0] : state == S_PARITY ? par_r : 1'b1;

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .push    (do_push),
        .pop     (do_pop),
        .din     (tx_d_in),
        .dout    (dout),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    always_comb begin
        state_nxt = state;
        if (do_pop)
            state_nxt = S_START;
        else if (tick)
            case (state)
                S_START:  state_nxt = S_DATA;
                S_DATA:   state_nxt = !last_bit ? S_DATA : pmode_r == PAR_NONE ? S_STOP : S_PARITY;
                S_PARITY: state_nxt = S_STOP;
                S_STOP:   state_nxt = stop_done ? S_IDLE : S_STOP;
                default:  state_nxt = S_IDLE;
            endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_r      <= 1'b0;
            div_r      <= '0;
            pmode_r    <= PAR_NONE;
            two_stop_r <= 1'b0;
            tx_data    <= 1'b1;
            tx_status  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state     <= state_nxt;
            baud_cnt  <= (state == S_IDLE || tick) ? '0 : baud_cnt + 16'd1;
            tx_data   <= line;
            tx_status <= do_push || !empty || state != S_IDLE;
            overflow  <= tx_valid && full;
            if (do_pop) begin
                div_r      <= baud_div(CLK_FREQ, sel_baud);
                pmode_r    <= parity_e'(parity_mode);
                two_stop_r <= two_stop;
            end
            if (tick && state == S_START) begin
                shreg   <= dout;
                bit_cnt <= '0;
                par_r   <= pmode_r == PAR_ODD ? ~^dout : pmode_r == PAR_EVEN ? ^dout : 1'b1;
            end
            if (tick && state == S_DATA) begin
                shreg   <= shreg >> 1;
                bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
            end
            if (tick && state == S_STOP)
                bit_cnt <= bit_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: directed frame vectors and corner sequences for uart_tx_param (8-bit and 5-bit builds)
module tb_uart_tx_param;
    localparam int CLK_FREQ = 1_152_000;
    logic sys_clk = 1'b0;
    logic rst_n, two_stop, tx_valid, tx_valid5, use5;
    logic [1:0] sel_baud, parity_mode;
    logic [7:0] tx_d_in;
    logic [4:0] tx_d_in5;
    logic tx_ready, tx_data, tx_status, overflow;
    logic tx_ready5, tx_data5, tx_status5, overflow5;
    logic [4:0] fifo_count;
    logic [2:0] fifo_count5;
    logic cur_line, cur_status;
    int total = 0;
    int bad = 0;

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  sel;
        logic [1:0]  pm;
        logic        ts;
        int          div;
        logic [11:0] bits;
        int          n;
    } vec_t;
    vec_t vecs[7];

    uart_tx_param #(.CLK_FREQ(CLK_FREQ), .DATA_BITS(8), .FIFO_DEPTH(16)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .sel_baud(sel_baud), .parity_mode(parity_mode),
        .two_stop(two_stop), .tx_valid(tx_valid), .tx_d_in(tx_d_in), .tx_ready(tx_ready),
        .tx_data(tx_data), .tx_status(tx_status), .fifo_count(fifo_count), .overflow(overflow)
    );

    uart_tx_param #(.CLK_FREQ(CLK_FREQ), .DATA_BITS(5), .FIFO_DEPTH(4)) dut5 (
        .sys_clk(sys_clk), .rst_n(rst_n), .sel_baud(sel_baud), .parity_mode(parity_mode),
        .two_stop(two_stop), .tx_valid(tx_valid5), .tx_d_in(tx_d_in5), .tx_ready(tx_ready5),
        .tx_data(tx_data5), .tx_status(tx_status5), .fifo_count(fifo_count5), .overflow(overflow5)
    );

    assign cur_line   = use5 ? tx_data5 : tx_data;
    assign cur_status = use5 ? tx_status5 : tx_status;

    always #5 sys_clk = ~sys_clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h want %0h", name, idx, act, exp);
        end
    endtask

    task automatic push(input bit to5, input logic [7:0] d);
        if (to5) begin
            tx_valid5 = 1'b1;
            tx_d_in5  = d[4:0];
        end else begin
            tx_valid = 1'b1;
            tx_d_in  = d;
        end
        tick();
        tx_valid  = 1'b0;
        tx_valid5 = 1'b0;
    endtask

    task automatic wait_fall(input int idx);
        int lat = 0;
        while (cur_line && lat < 50) begin
            tick();
            lat++;
        end
        chk("start_latency", idx, lat, 2);
    endtask

    // bits[11] is the first bit on the line (start), then payload LSB first, parity, stop(s)
    task automatic frame_bits(input int idx, input logic [11:0] bits, input int n, input int div, input bit last);
        for (int k = 0; k < n * div; k++) begin
            if (k % div == 0 || k % div == div - 1)
                chk("line_bit", idx * 100 + k / div, cur_line, bits[11 - k / div]);
            if (k == n * div - 1)
                chk("status_busy", idx, cur_status, 1);
            tick();
        end
        if (last) begin
            chk("status_end", idx, cur_status, 0);
            chk("line_idle", idx, cur_line, 1);
            chk("count_end", idx, use5 ? fifo_count5 : fifo_count, 0);
        end
    endtask

    function automatic logic [11:0] frame_none(input logic [7:0] d);
        logic [11:0] f;
        f = '0;
        for (int j = 0; j < 8; j++)
            f[10 - j] = d[j];
        f[2] = 1'b1;
        return f;
    endfunction

    initial begin
        // divisors at 1.152 MHz: 4800 -> 240, 9600 -> 120, 19200 -> 60, 115200 -> 10
        vecs[0] = '{8'hA5, 2'b01, 2'b00, 1'b0, 120, 12'b010100101100, 10};
        vecs[1] = '{8'h3C, 2'b10, 2'b10, 1'b1,  60, 12'b000111100011, 12};
        vecs[2] = '{8'h3D, 2'b11, 2'b01, 1'b0,  10, 12'b010111100010, 11};
        vecs[3] = '{8'h00, 2'b11, 2'b11, 1'b0,  10, 12'b000000000110, 11};
        vecs[4] = '{8'h01, 2'b11, 2'b10, 1'b0,  10, 12'b010000000110, 11};
        vecs[5] = '{8'hFF, 2'b00, 2'b11, 1'b1, 240, 12'b011111111111, 12};
        vecs[6] = '{8'h5A, 2'b11, 2'b00, 1'b1,  10, 12'b001011010110, 11};

        rst_n = 1'b0; tx_valid = 1'b0; tx_valid5 = 1'b0; tx_d_in = '0; tx_d_in5 = '0;
        sel_baud = 2'b11; parity_mode = 2'b00; two_stop = 1'b0; use5 = 1'b0;
        repeat (3) tick();
        chk("rst_tx_data", 0, tx_data, 1);
        chk("rst_tx_status", 0, tx_status, 0);
        chk("rst_fifo_count", 0, fifo_count, 0);
        chk("rst_overflow", 0, overflow, 0);
        chk("rst_tx_ready", 0, tx_ready, 1);
        chk("rst_tx_data5", 0, tx_data5, 1);
        chk("rst_tx_ready5", 0, tx_ready5, 1);
        rst_n = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 7; i++) begin
            sel_baud = vecs[i].sel; parity_mode = vecs[i].pm; two_stop = vecs[i].ts;
            push(1'b0, vecs[i].data);
            chk("count_after_push", i, fifo_count, 1);
            chk("status_after_push", i, tx_status, 1);
            wait_fall(i);
            frame_bits(i, vecs[i].bits, vecs[i].n, vecs[i].div, 1'b1);
            repeat (3) tick();
        end

        // config change mid-frame: frame 1 keeps 9600, frame 2 picks up 115200
        sel_baud = 2'b01; parity_mode = 2'b00; two_stop = 1'b0;
        tx_valid = 1'b1; tx_d_in = 8'hA5;
        tick();
        chk("mid_count_first", 0, fifo_count, 1);
        tx_d_in = 8'h3C;
        tick();
        chk("mid_count_pushpop", 0, fifo_count, 1);
        tx_valid = 1'b0;
        tick();
        chk("mid_fall", 0, tx_data, 0);
        sel_baud = 2'b11;
        frame_bits(20, 12'b010100101100, 10, 120, 1'b0);
        frame_bits(21, 12'b000111100100, 10, 10, 1'b1);
        repeat (3) tick();

        // burst to full while one frame is in flight
        push(1'b0, 8'h96);
        wait_fall(30);
        fork
            frame_bits(30, frame_none(8'h96), 10, 10, 1'b0);
            begin
                for (int i = 0; i < 17; i++) begin
                    tx_valid = 1'b1;
                    tx_d_in  = 8'(i * 37 + 5);
                    tick();
                    chk("burst_count", i, fifo_count, i < 16 ? i + 1 : 16);
                    chk("burst_ready", i, tx_ready, i < 15);
                    chk("burst_overflow", i, overflow, i == 16);
                end
                tx_valid = 1'b0;
                tick();
                chk("burst_overflow_clear", 0, overflow, 0);
            end
        join
        for (int i = 0; i < 16; i++)
            frame_bits(31 + i, frame_none(8'(i * 37 + 5)), 10, 10, i == 15);
        repeat (3) tick();

        // reset during data bits with three words queued
        tx_valid = 1'b1;
        tx_d_in  = 8'h00;
        for (int i = 0; i < 4; i++)
            tick();
        tx_valid = 1'b0;
        chk("rst_queued", 0, fifo_count, 3);
        repeat (25) tick();
        chk("rst_pre_line", 0, tx_data, 0);
        rst_n = 1'b0;
        tick();
        chk("midrst_tx_data", 0, tx_data, 1);
        chk("midrst_count", 0, fifo_count, 0);
        chk("midrst_status", 0, tx_status, 0);
        chk("midrst_ready", 0, tx_ready, 1);
        rst_n = 1'b1;
        begin
            int noisy = 0;
            for (int i = 0; i < 200; i++) begin
                tick();
                if (!tx_data || tx_status)
                    noisy++;
            end
            chk("post_reset_quiet", 0, noisy, 0);
        end

        // 5-bit build: 0x15 -> payload 1,0,1,0,1 in a 7-bit frame
        use5 = 1'b1;
        sel_baud = 2'b11; parity_mode = 2'b00; two_stop = 1'b0;
        push(1'b1, 8'h15);
        chk("n5_count", 0, fifo_count5, 1);
        wait_fall(60);
        frame_bits(60, 12'b010101100000, 7, 10, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
